// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// ---------------------------------------------------------------------------
// Issue controller for a floating-point unit with a fixed-latency pipeline
// and an iterative divide/sqrt unit. It decides every cycle whether the FP
// instruction held in decode may be sent to the FPU. It also tracks which FP
// registers still have a result outstanding, and when each result returns on
// the single shared writeback port.
//
// Parameters
//   DIV_LAT   latency of the divide/sqrt class in cycles (5..31)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   id_valid   decode holds an FP instruction that wants to issue
//   id_class   latency class: 0 move/cmp/sgnj, 1 add/sub/mul, 2 fma, 3 div/sqrt
//   id_rd      destination FP register
//   id_rd_we   instruction writes the FP register file
//   id_rs1..3  source FP registers
//   id_rs_use  bit i set means source rs(i+1) is read
//   flush      kill the decode-stage instruction this cycle
//   issue      one-cycle FPU input-valid strobe (combinational)
//   stall      hold fetch/decode this cycle (combinational)
//   busy       divide/sqrt unit occupied
//   wb_valid   FP result writeback strobe
//   wb_rd      FP result writeback register
//   pending    per-register outstanding-write mask
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
   parameter int DIV_LAT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [1:0]  id_class,
   input  logic [4:0]  id_rd,
   input  logic        id_rd_we,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rs3,
   input  logic [2:0]  id_rs_use,
   input  logic        flush,
   output logic        issue,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] pending
);

   localparam int SW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

   // Reservation slots: res_valid[k] set means a result for res_rd[k]
   // returns on the writeback port k cycles from now.
   logic [DIV_LAT-1:0] res_valid;
   logic [4:0]         res_rd [DIV_LAT];

   logic [31:0] pending_q;
   logic        busy_q;
   logic [4:0]  div_cnt;

   logic [4:0]  lat;
   logic [SW-1:0] load_idx;
   logic [SW-1:0] probe_idx;
   logic [31:0] bypass_mask;
   logic [31:0] live_mask;
   logic        raw_hz;
   logic        waw_hz;
   logic        wb_hz;
   logic        div_hz;

   assign wb_valid = res_valid[0];
   assign wb_rd    = res_rd[0];
   assign pending  = pending_q;
   assign busy     = busy_q;

   // Translate the latency class into the number of cycles between issue and
   // writeback, and derive the slot this instruction will occupy (L-1 after
   // the shift) and the slot that would collide with it (L before the shift).
   always_comb begin
      lat = 5'd1;
      case (id_class)
         2'd0:    lat = 5'd1;
         2'd1:    lat = 5'd3;
         2'd2:    lat = 5'd4;
         default: lat = 5'(DIV_LAT);
      endcase
      load_idx  = SW'(lat - 5'd1);
      probe_idx = SW'(lat);
   end

   // Hazard detection. A register being written back this very cycle is
   // treated as already available, so its pending bit is masked out for both
   // the source (RAW) and destination (WAW) checks. Slot DIV_LAT does not
   // exist, so a divide can never collide on the writeback port. The divider
   // itself is not pipelined and does not bypass: a second divide waits until
   // busy has dropped.
   always_comb begin
      bypass_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
      live_mask   = pending_q & ~bypass_mask;
      raw_hz      = (id_rs_use[0] & live_mask[id_rs1]) |
                    (id_rs_use[1] & live_mask[id_rs2]) |
                    (id_rs_use[2] & live_mask[id_rs3]);
      waw_hz      = id_rd_we & live_mask[id_rd];
      wb_hz       = (lat < 5'(DIV_LAT)) ? res_valid[probe_idx] : 1'b0;
      div_hz      = (id_class == 2'd3) & busy_q;
   end

   // Issue and stall are purely combinational. Flush and reset both
   // suppress them, so a killed instruction neither issues nor holds decode.
   always_comb begin
      issue = id_valid & ~flush & ~rst & ~(raw_hz | waw_hz | wb_hz | div_hz);
      stall = id_valid & ~flush & ~rst & ~issue;
   end

   // Reservation shift register. Every cycle each slot moves one step closer
   // to writeback, with an empty slot entering at the top. A writing issue
   // then drops its destination into slot L-1; the writeback hazard check
   // guarantees that slot was empty after the shift. Non-writing issues
   // leave the slots untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= '0;
         for (int k = 0; k < DIV_LAT; k++) begin
            res_rd[k] <= 5'd0;
         end
      end else begin
         res_valid <= {1'b0, res_valid[DIV_LAT-1:1]};
         for (int k = 0; k < DIV_LAT - 1; k++) begin
            res_rd[k] <= res_rd[k+1];
         end
         res_rd[DIV_LAT-1] <= 5'd0;
         if (issue && id_rd_we) begin
            res_valid[load_idx] <= 1'b1;
            res_rd[load_idx]    <= id_rd;
         end
      end
   end

   // Outstanding-write scoreboard. A bit clears after the cycle its result
   // is written back, and sets after a writing issue. If a WAW bypass issues
   // a new write to the register that is retiring this cycle, the set wins,
   // because the new result is still outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 32'd0;
      end else begin
         pending_q <= (pending_q & ~bypass_mask) |
                      ((issue && id_rd_we) ? (32'd1 << id_rd) : 32'd0);
      end
   end

   // Divider occupancy. A countdown is used rather than the reservation
   // slots because a divide that does not write the FP file still occupies
   // the divider. Loading DIV_LAT-1 makes busy drop at the edge that ends
   // the divide's writeback cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         div_cnt <= 5'd0;
      end else if (busy_q) begin
         if (div_cnt == 5'd0) begin
            busy_q <= 1'b0;
         end else begin
            div_cnt <= div_cnt - 5'd1;
         end
      end else if (issue && (id_class == 2'd3)) begin
         busy_q  <= 1'b1;
         div_cnt <= 5'(DIV_LAT - 1);
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for fpu_issue_ctrl with DIV_LAT = 12. Directed
// scenarios drive decode requests. Each one checks issue, stall, busy and
// pending against hand-derived constants, and queues the writeback it
// expects: the cycle index and the register. A monitor pops the queue
// whenever wb_valid is seen and flags early, late or unexpected writebacks.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [1:0]  id_class;
   logic [4:0]  id_rd;
   logic        id_rd_we;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rs3;
   logic [2:0]  id_rs_use;
   logic        flush;
   logic        issue;
   logic        stall;
   logic        busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] pending;

   typedef struct {
      int         cyc;
      logic [4:0] rd;
   } wb_exp_t;

   wb_exp_t sb[$];
   int      cyc;
   int      n_checks;
   int      n_pass;
   logic    mon_en;
   int      t0;

   fpu_issue_ctrl #(.DIV_LAT(12)) dut (
      .clk(clk),
      .rst(rst),
      .id_valid(id_valid),
      .id_class(id_class),
      .id_rd(id_rd),
      .id_rd_we(id_rd_we),
      .id_rs1(id_rs1),
      .id_rs2(id_rs2),
      .id_rs3(id_rs3),
      .id_rs_use(id_rs_use),
      .flush(flush),
      .issue(issue),
      .stall(stall),
      .busy(busy),
      .wb_valid(wb_valid),
      .wb_rd(wb_rd),
      .pending(pending)
   );

   // Free-running clock with a period of 10 time units.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index: bumped at every rising edge, so it names the current cycle.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Every comparison funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                                input logic we, input logic [4:0] rs1, input logic [2:0] use_,
                                input logic fl, input logic r);
      id_valid  = v;
      id_class  = cls;
      id_rd     = rd;
      id_rd_we  = we;
      id_rs1    = rs1;
      id_rs_use = use_;
      flush     = fl;
      rst       = r;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expectWb(input int due, input logic [4:0] rd);
      wb_exp_t e;
      e.cyc = due;
      e.rd  = rd;
      sb.push_back(e);
   endtask

   // Idle until every queued writeback has been seen, within a bounded budget.
   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         nextCycle();
         idle();
      end
      checkOutput("drain_empty", sb.size(), 0);
   endtask

   // Writeback monitor. It first retires expectations whose cycle has passed
   // without a writeback, then matches any writeback against the queue head.
   always @(negedge clk) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checkOutput("wb_missed_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("wb_unexpected_valid", {31'd0, wb_valid}, 32'd0);
            end else begin
               checkOutput("wb_cycle", cyc, sb[0].cyc);
               checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, sb[0].rd});
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mon_en   = 1'b0;
      id_rs2   = 5'd0;
      id_rs3   = 5'd0;

      // Reset with a request present: issue and stall must be held low.
      applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 5'd0, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("rst_issue", {31'd0, issue}, 32'd0);
      checkOutput("rst_stall", {31'd0, stall}, 32'd0);
      nextCycle();
      @(negedge clk);
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      checkOutput("rst_pending", pending, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      mon_en = 1'b1;

      // Basic add: issue t0, pending t1..t3, writeback t3, clear t4.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 3, 5'd3);
      @(negedge clk);
      checkOutput("add_issue", {31'd0, issue}, 32'd1);
      checkOutput("add_stall", {31'd0, stall}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         nextCycle();
         idle();
         @(negedge clk);
         checkOutput("add_pending_set", {31'd0, pending[3]}, 32'd1);
      end
      nextCycle();
      @(negedge clk);
      checkOutput("add_pending_clr", pending, 32'd0);
      drain();

      // RAW: fma writes f5, then a move reads f5. Stall t1..t3, bypass at t4.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd2, 5'd5, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 4, 5'd5);
      @(negedge clk);
      checkOutput("raw_first_issue", {31'd0, issue}, 32'd1);
      for (int i = 1; i <= 3; i++) begin
         nextCycle();
         applyStimulus(1'b1, 2'd0, 5'd6, 1'b1, 5'd5, 3'b001, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput("raw_stall", {31'd0, stall}, 32'd1);
         checkOutput("raw_no_issue", {31'd0, issue}, 32'd0);
      end
      nextCycle();
      expectWb(cyc + 1, 5'd6);
      @(negedge clk);
      checkOutput("raw_bypass_issue", {31'd0, issue}, 32'd1);
      checkOutput("raw_bypass_stall", {31'd0, stall}, 32'd0);
      nextCycle();
      idle();
      drain();

      // Writeback port collision: add at t0, move requested at t2.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd1, 5'd7, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 3, 5'd7);
      @(negedge clk);
      checkOutput("col_first_issue", {31'd0, issue}, 32'd1);
      nextCycle();
      idle();
      nextCycle();
      applyStimulus(1'b1, 2'd0, 5'd8, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("col_stall", {31'd0, stall}, 32'd1);
      checkOutput("col_no_issue", {31'd0, issue}, 32'd0);
      nextCycle();
      expectWb(t0 + 4, 5'd8);
      @(negedge clk);
      checkOutput("col_issue", {31'd0, issue}, 32'd1);
      nextCycle();
      idle();
      drain();

      // Divider: back-to-back divides, the second issues at t13.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd3, 5'd9, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 12, 5'd9);
      @(negedge clk);
      checkOutput("div_first_issue", {31'd0, issue}, 32'd1);
      checkOutput("div_busy_t0", {31'd0, busy}, 32'd0);
      for (int i = 1; i <= 12; i++) begin
         nextCycle();
         applyStimulus(1'b1, 2'd3, 5'd10, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput("div_stall", {31'd0, stall}, 32'd1);
         checkOutput("div_busy", {31'd0, busy}, 32'd1);
      end
      nextCycle();
      expectWb(t0 + 25, 5'd10);
      @(negedge clk);
      checkOutput("div_second_issue", {31'd0, issue}, 32'd1);
      checkOutput("div_busy_t13", {31'd0, busy}, 32'd0);
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("div_busy_t14", {31'd0, busy}, 32'd1);
      drain();
      checkOutput("div_busy_end", {31'd0, busy}, 32'd0);

      // Flush of a new request while an add is in flight.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 3, 5'd3);
      @(negedge clk);
      checkOutput("fl_first_issue", {31'd0, issue}, 32'd1);
      nextCycle();
      idle();
      nextCycle();
      applyStimulus(1'b1, 2'd0, 5'd4, 1'b1, 5'd0, 3'b000, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("fl_issue", {31'd0, issue}, 32'd0);
      checkOutput("fl_stall", {31'd0, stall}, 32'd0);
      checkOutput("fl_pending", pending, 32'h0000_0008);
      nextCycle();
      idle();
      drain();

      // Reset mid-flight discards the in-flight add.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 3, 5'd3);
      @(negedge clk);
      checkOutput("mr_issue", {31'd0, issue}, 32'd1);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 5'd1, 1'b1, 5'd0, 3'b000, 1'b0, 1'b1);
      sb.delete();
      @(negedge clk);
      checkOutput("mr_rst_issue", {31'd0, issue}, 32'd0);
      checkOutput("mr_rst_stall", {31'd0, stall}, 32'd0);
      for (int i = 2; i <= 5; i++) begin
         nextCycle();
         idle();
         @(negedge clk);
         checkOutput("mr_pending", pending, 32'd0);
         checkOutput("mr_no_wb", {31'd0, wb_valid}, 32'd0);
      end

      // WAW: fma writes f11, then an add to f11 waits and issues via bypass.
      nextCycle();
      t0 = cyc;
      applyStimulus(1'b1, 2'd2, 5'd11, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
      expectWb(t0 + 4, 5'd11);
      @(negedge clk);
      checkOutput("waw_first_issue", {31'd0, issue}, 32'd1);
      for (int i = 1; i <= 3; i++) begin
         nextCycle();
         applyStimulus(1'b1, 2'd1, 5'd11, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput("waw_stall", {31'd0, stall}, 32'd1);
      end
      nextCycle();
      expectWb(t0 + 7, 5'd11);
      @(negedge clk);
      checkOutput("waw_issue", {31'd0, issue}, 32'd1);
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("waw_pending_kept", pending, 32'h0000_0800);
      drain();
      checkOutput("waw_pending_end", pending, 32'd0);

      // A non-writing issue occupies no slot and sets no pending bit.
      nextCycle();
      applyStimulus(1'b1, 2'd1, 5'd12, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("nw_issue", {31'd0, issue}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         nextCycle();
         idle();
         @(negedge clk);
         checkOutput("nw_pending", pending, 32'd0);
      end

      nextCycle();
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
